// File: rtl/fib2axis_rxctrl_pkg.sv
// rtl/fib2axis_rxctrl_pkg.sv - shared definitions for the fibre-to-AXIS RX control path
package fib2axis_rxctrl_pkg;

    localparam int DATA_BYTES   = 8;
    localparam int BCNT_LEN_MSB = 15;
    localparam int BCNT_BAD_BIT = 31;

    typedef enum logic [4:0] {
        RX_IDLE = 5'h01,
        RX_BCNT = 5'h02,
        RX_LEN  = 5'h04,
        RX_DATA = 5'h08,
        RX_DONE = 5'h10
    } rx_state_t;

    typedef struct packed {
        logic [DATA_BYTES*8-1:0] tdata;
        logic [DATA_BYTES-1:0]   tstrb;
        logic                    tlast;
        logic                    tuser;
    } rx_beat_t;

    function automatic logic [13:0] beat_count(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd7;
        return sum[16:3];
    endfunction

    // A partial last word keeps only its low len[2:0] bytes.
    function automatic logic [7:0] last_keep(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hff : (8'hff >> (4'd8 - {1'b0, rem}));
    endfunction

endpackage

// File: rtl/fib2axis_rxctrl_skid.sv
// rtl/fib2axis_rxctrl_skid.sv - 2-entry skid buffer feeding the RX AXI-Stream master
module fib2axis_rxctrl_skid
    import fib2axis_rxctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_,
    input  logic       wr_en,
    input  rx_beat_t   wr_beat,
    output logic [1:0] occupancy,
    output logic       full,
    output logic       out_valid,
    output rx_beat_t   out_beat,
    input  logic       out_ready
);

    rx_beat_t tail;
    logic     pop;

    assign out_valid = (occupancy != 2'd0);
    assign full      = (occupancy == 2'd2);
    assign pop       = out_valid & out_ready;

    // out_beat is the head entry; it only changes when empty or when popped.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occupancy <= 2'd0;
            out_beat  <= '0;
            tail      <= '0;
        end else begin
            case (occupancy)
                2'd0: begin
                    if (wr_en) begin
                        out_beat  <= wr_beat;
                        occupancy <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_en && pop) begin
                        out_beat <= wr_beat;
                    end else if (wr_en) begin
                        tail      <= wr_beat;
                        occupancy <= 2'd2;
                    end else if (pop) begin
                        occupancy <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        out_beat <= tail;
                        if (wr_en) tail <= wr_beat;
                        else       occupancy <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fib2axis_rxctrl.sv
// rtl/fib2axis_rxctrl.sv - pops RX byte counts and data words, drives the MAC-side AXI-Stream master
module fib2axis_rxctrl
    import fib2axis_rxctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DATA_PTR   = 8,
    parameter int BCNT_WIDTH = 32,
    parameter int BCNT_PTR   = 2
) (
    input  logic                  clk,
    input  logic                  reset_,
    output logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
    output logic                  rx_axis_mac_tvalid,
    output logic                  rx_axis_mac_tlast,
    output logic                  rx_axis_mac_tuser,
    output logic [7:0]            rx_axis_mac_tstrb,
    input  logic                  rx_axis_mac_tready,
    input  logic [BCNT_WIDTH-1:0] rd_rxbcnt_fifo,
    output logic                  rxbcnt_rdreq,
    input  logic                  rxbcnt_rdempty,
    input  logic [BCNT_PTR:0]     rxbcnt_rdusedw,
    input  logic [DATA_WIDTH-1:0] rd_rxdata_fifo,
    output logic                  rxdata_rdreq,
    input  logic                  rxdata_rdempty,
    input  logic [DATA_PTR:0]     rxdata_rdusedw,
    output logic [31:0]           rx_statistics_vector,
    output logic                  rx_statistics_valid,
    output logic                  test
);

    rx_state_t   state;
    logic [15:0] len_q;
    logic        bad_q;
    logic [13:0] beats_q;
    logic [13:0] rd_left;
    logic [13:0] wr_cnt;
    logic [7:0]  lastkeep_q;
    logic        inflight;

    logic [15:0] bcnt_len;
    logic        bcnt_bad;
    logic [1:0]  skid_occ;
    logic        skid_full;
    logic        pop;
    logic [2:0]  pending;
    rx_beat_t    wr_beat;
    rx_beat_t    out_beat;

    assign bcnt_len = rd_rxbcnt_fifo[BCNT_LEN_MSB:0];
    assign bcnt_bad = rd_rxbcnt_fifo[BCNT_BAD_BIT];
    assign pop      = rx_axis_mac_tvalid & rx_axis_mac_tready;
    assign pending  = {1'b0, skid_occ} + {2'b0, inflight};

    // A word popped this cycle frees a slot, so a full pipeline keeps 1 beat/clk.
    assign rxdata_rdreq = (state == RX_DATA) && (rd_left != 14'd0) && !rxdata_rdempty &&
                          (pending < (3'd2 + {2'b0, pop}));

    always_comb begin
        wr_beat       = '0;
        wr_beat.tdata = rd_rxdata_fifo;
        wr_beat.tlast = (wr_cnt == beats_q - 14'd1);
        wr_beat.tstrb = wr_beat.tlast ? lastkeep_q : 8'hff;
        wr_beat.tuser = wr_beat.tlast & bad_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state                <= RX_IDLE;
            rxbcnt_rdreq         <= 1'b0;
            len_q                <= '0;
            bad_q                <= 1'b0;
            beats_q              <= '0;
            lastkeep_q           <= '0;
            rd_left              <= '0;
            wr_cnt               <= '0;
            inflight             <= 1'b0;
            rx_statistics_vector <= '0;
            rx_statistics_valid  <= 1'b0;
        end else begin
            rxbcnt_rdreq        <= 1'b0;
            rx_statistics_valid <= 1'b0;
            inflight            <= rxdata_rdreq;
            if (inflight)     wr_cnt  <= wr_cnt + 14'd1;
            if (rxdata_rdreq) rd_left <= rd_left - 14'd1;
            case (state)
                RX_IDLE: begin
                    if (!rxbcnt_rdempty) begin
                        state        <= RX_BCNT;
                        rxbcnt_rdreq <= 1'b1;
                    end
                end
                RX_BCNT: state <= RX_LEN;
                RX_LEN: begin
                    len_q      <= bcnt_len;
                    bad_q      <= bcnt_bad;
                    beats_q    <= beat_count(bcnt_len);
                    rd_left    <= beat_count(bcnt_len);
                    lastkeep_q <= last_keep(bcnt_len[2:0]);
                    wr_cnt     <= '0;
                    state      <= (bcnt_len == 16'd0) ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (rxdata_rdreq && rd_left == 14'd1) state <= RX_DONE;
                end
                RX_DONE: begin
                    if (pop && out_beat.tlast) begin
                        state                <= RX_IDLE;
                        rx_statistics_vector <= {bad_q, 15'b0, len_q};
                        rx_statistics_valid  <= 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    fib2axis_rxctrl_skid u_skid (
        .clk       (clk),
        .reset_    (reset_),
        .wr_en     (inflight),
        .wr_beat   (wr_beat),
        .occupancy (skid_occ),
        .full      (skid_full),
        .out_valid (rx_axis_mac_tvalid),
        .out_beat  (out_beat),
        .out_ready (rx_axis_mac_tready)
    );

    assign rx_axis_mac_tdata = out_beat.tdata;
    assign rx_axis_mac_tstrb = out_beat.tstrb;
    assign rx_axis_mac_tlast = out_beat.tlast;
    assign rx_axis_mac_tuser = out_beat.tuser;
    assign test              = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{rxbcnt_rdusedw, rxdata_rdusedw,
                         rd_rxbcnt_fifo[BCNT_BAD_BIT-1:BCNT_LEN_MSB+1], skid_full};

endmodule

// File: tb/tb_fib2axis_rxctrl.sv
// tb/tb_fib2axis_rxctrl.sv - self-checking bench for fib2axis_rxctrl
module tb_fib2axis_rxctrl;

    logic        clk = 1'b0;
    logic        reset_;
    logic [63:0] tdata;
    logic        tvalid, tlast, tuser;
    logic [7:0]  tstrb;
    logic        tready;
    logic [31:0] rd_rxbcnt_fifo;
    logic        rxbcnt_rdreq, rxbcnt_rdempty;
    logic [2:0]  rxbcnt_rdusedw;
    logic [63:0] rd_rxdata_fifo;
    logic        rxdata_rdreq, rxdata_rdempty;
    logic [8:0]  rxdata_rdusedw;
    logic [31:0] stats_vec;
    logic        stats_valid;
    logic        test;

    always #2 clk = ~clk;

    fib2axis_rxctrl dut (
        .clk                  (clk),
        .reset_               (reset_),
        .rx_axis_mac_tdata    (tdata),
        .rx_axis_mac_tvalid   (tvalid),
        .rx_axis_mac_tlast    (tlast),
        .rx_axis_mac_tuser    (tuser),
        .rx_axis_mac_tstrb    (tstrb),
        .rx_axis_mac_tready   (tready),
        .rd_rxbcnt_fifo       (rd_rxbcnt_fifo),
        .rxbcnt_rdreq         (rxbcnt_rdreq),
        .rxbcnt_rdempty       (rxbcnt_rdempty),
        .rxbcnt_rdusedw       (rxbcnt_rdusedw),
        .rd_rxdata_fifo       (rd_rxdata_fifo),
        .rxdata_rdreq         (rxdata_rdreq),
        .rxdata_rdempty       (rxdata_rdempty),
        .rxdata_rdusedw       (rxdata_rdusedw),
        .rx_statistics_vector (stats_vec),
        .rx_statistics_valid  (stats_valid),
        .test                 (test)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic        l;
        logic        u;
    } beat_t;

    logic [31:0] bq[$];
    logic [63:0] dq[$];
    logic [63:0] held_q[$];
    beat_t       exp_q[$];
    logic [31:0] stat_q[$];
    int          len_q[$];

    int   checks = 0, failures = 0;
    int   cyc = 0, first_cyc = 0, last_cyc = 0, beat_idx = 0;
    int   rd_cnt = 0, acc_total = 0;
    int   rdy_mode = 0, feed_mode = 0;
    logic busy = 1'b0, stats_due = 1'b0, prev_stall = 1'b0, acc;
    logic [73:0] prev_beat = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO read sides: non-showahead, empty/usedw registered.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rd_rxdata_fifo <= '0;
            rd_rxbcnt_fifo <= '0;
            rxdata_rdempty <= 1'b1;
            rxbcnt_rdempty <= 1'b1;
            rxdata_rdusedw <= '0;
            rxbcnt_rdusedw <= '0;
        end else begin
            if (rxdata_rdreq && dq.size() > 0) rd_rxdata_fifo <= dq.pop_front();
            if (rxbcnt_rdreq && bq.size() > 0) rd_rxbcnt_fifo <= bq.pop_front();
            rxdata_rdempty <= (dq.size() == 0);
            rxbcnt_rdempty <= (bq.size() == 0);
            rxdata_rdusedw <= 9'(dq.size());
            rxbcnt_rdusedw <= 3'(bq.size());
        end
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (reset_) begin
            if (prev_stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_beat", {tdata, tstrb, tlast, tuser}, prev_beat);
            end
            chk("stats_pulse", stats_valid, stats_due);
            if (stats_valid) begin
                if (stat_q.size() > 0) chk("stats_vec", stats_vec, stat_q.pop_front());
                else                   chk("stats_extra", stats_valid, 0);
            end
            acc       = tvalid && tready;
            stats_due = acc && tlast;
            if (rxdata_rdreq) begin
                chk("rdreq_empty", rxdata_rdempty, 0);
                chk("skid_cap", (rd_cnt - acc_total - (acc ? 1 : 0)) < 2, 1);
                rd_cnt++;
            end
            if (rxbcnt_rdreq) begin
                chk("bcnt_busy", busy, 0);
                if (len_q.size() > 0) busy = (len_q.pop_front() != 0);
            end
            if (acc) begin
                acc_total++;
                if (exp_q.size() == 0) chk("extra_beat", tvalid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", {tdata, tstrb, tlast, tuser}, {e.d, e.s, e.l, e.u});
                    if (beat_idx == 0) first_cyc = cyc;
                    beat_idx++;
                end
                if (tlast) begin
                    last_cyc = cyc;
                    beat_idx = 0;
                    busy     = 1'b0;
                end
            end
            prev_stall = tvalid && !tready;
            prev_beat  = {tdata, tstrb, tlast, tuser};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
        if (held_q.size() > 0 && (feed_mode == 0 || (feed_mode == 1 && $urandom_range(0, 2) != 0)))
            dq.push_back(held_q.pop_front());
    endtask

    // Expected beats come straight from the byte count: ceil(len/8) words, the last one keeping len%8 bytes.
    task automatic push_frame(input int len, input logic bad, input int npre);
        int    n;
        int    rem;
        beat_t b;
        n   = (len + 7) / 8;
        rem = len % 8;
        bq.push_back({bad, 15'b0, 16'(len)});
        len_q.push_back(len);
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom(), $urandom()};
            b.l = (i == n - 1);
            b.s = (b.l && rem != 0) ? 8'((1 << rem) - 1) : 8'hff;
            b.u = b.l & bad;
            if (i < npre && held_q.size() == 0) dq.push_back(b.d);
            else                                held_q.push_back(b.d);
            exp_q.push_back(b);
        end
        if (n > 0) stat_q.push_back({bad, 15'b0, 16'(len)});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || held_q.size() > 0 || stat_q.size() > 0 ||
                bq.size() > 0 || stats_due) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", n < budget, 1);
        repeat (3) step();
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {tdata, tvalid, tlast, tuser, tstrb, rxbcnt_rdreq, rxdata_rdreq,
                  stats_vec, stats_valid, test}, 0);
    endtask

    initial begin
        int n;
        tready = 1'b1;
        reset_ = 1'b0;
        #1;
        chk_zero("reset_state");
        repeat (3) step();
        reset_ = 1'b1;
        step();

        // 1: len=64 preloaded, full throughput
        push_frame(64, 1'b0, 8);
        wait_done(200);
        chk("t1_consecutive", last_cyc - first_cyc, 7);

        // 2: len=13 bad frame
        push_frame(13, 1'b1, 2);
        wait_done(200);

        // 3: tready toggling
        rdy_mode = 1;
        push_frame(64, 1'b0, 8);
        wait_done(400);
        rdy_mode = 0;

        // 4: rxdata runs dry after word 3 of len=40
        feed_mode = 2;
        push_frame(40, 1'b0, 3);
        n = 0;
        while (exp_q.size() > 2 && n < 200) begin step(); n++; end
        chk("t4_reach", exp_q.size(), 2);
        repeat (5) begin
            step();
            chk("t4_gap", tvalid, 0);
        end
        feed_mode = 0;
        wait_done(200);

        // 5: len=0 dropped, then len=8
        push_frame(0, 1'b0, 0);
        push_frame(8, 1'b0, 1);
        wait_done(200);

        // boundary: len 1..8 and the maximum length
        for (int l = 1; l <= 8; l++) begin
            push_frame(l, 1'($urandom_range(0, 1)), 1);
            wait_done(200);
        end
        push_frame(65535, 1'b1, 8192);
        wait_done(9000);
        chk("t_max_consecutive", last_cyc - first_cyc, 8191);

        // 6: async reset during beat 4
        push_frame(64, 1'b0, 8);
        n = 0;
        while (acc_total < 3 + (acc_total / 3) * 0 && n < 0) n++;
        n = 0;
        begin
            int base;
            base = acc_total;
            while (acc_total < base + 3 && n < 200) begin step(); n++; end
            chk("t6_reach", acc_total - base, 3);
        end
        reset_ = 1'b0;
        #1;
        chk_zero("t6_async_reset");
        dq.delete(); bq.delete(); held_q.delete(); exp_q.delete(); stat_q.delete(); len_q.delete();
        busy = 1'b0; stats_due = 1'b0; prev_stall = 1'b0; beat_idx = 0;
        rd_cnt = 0; acc_total = 0;
        repeat (3) step();
        chk_zero("t6_held_reset");
        reset_ = 1'b1;
        repeat (4) step();
        chk("t6_idle", {rxbcnt_rdreq, rxdata_rdreq, tvalid}, 0);
        push_frame(20, 1'b0, 3);
        wait_done(200);

        // randomized traffic: back-to-back frames, random tready and FIFO refill
        rdy_mode  = 2;
        feed_mode = 1;
        for (int f = 0; f < 12; f++) begin
            push_frame($urandom_range(0, 120), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            push_frame($urandom_range(1, 120), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            wait_done(3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
